rf_wb_ctrl: RTL and testbench

- Write-side controller for the CPU's 32x32 register file (async read, x0 hardwired zero, one write port).
- Merges single-cycle ALU results and long-latency results (load/mul/div unit, "LU") into one registered write port: we/wa/wd.
- Keeps a busy scoreboard for registers with an outstanding long-latency write, so decode can stall on RAW/WAW hazards.

---
 rtl/rv_pkg.sv | 10 +
 rtl/rf_wb_ctrl_if.sv | 44 ++++
 rtl/wb_fifo.sv | 45 ++++
 rtl/rf_wb_ctrl.sv | 80 ++++++++
 tb/tb_rf_wb_ctrl.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// rv_pkg: shared register-file widths and the write-back entry type.
package rv_pkg;
  localparam int XLEN     = 32;
  localparam int REG_AW   = 5;
  localparam int NUM_REGS = 32;
  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   wd;
  } wb_entry_t;
endpackage

// File: rtl/rf_wb_ctrl_if.sv
// rf_wb_ctrl_if: decode/execute-side bus of the register-file write-back controller.
// Bypass signals exist only when RF_WB_BYPASS_EN is defined.
interface rf_wb_ctrl_if;
  import rv_pkg::*;
  logic              alu_valid;
  logic [REG_AW-1:0] alu_rd;
  logic [XLEN-1:0]   alu_wd;
  logic              lu_valid;
  logic              lu_ready;
  logic [REG_AW-1:0] lu_rd;
  logic [XLEN-1:0]   lu_wd;
  logic              issue_valid;
  logic [REG_AW-1:0] issue_rd;
  logic [REG_AW-1:0] ra1;
  logic [REG_AW-1:0] ra2;
  logic              busy_rs1;
  logic              busy_rs2;
  logic              busy_rd;
  logic              we;
  logic [REG_AW-1:0] wa;
  logic [XLEN-1:0]   wd;
`ifdef RF_WB_BYPASS_EN
  logic              byp1_hit;
  logic              byp2_hit;
  logic [XLEN-1:0]   byp_data;
  modport master (
    output alu_valid, alu_rd, alu_wd, lu_valid, lu_rd, lu_wd, issue_valid, issue_rd, ra1, ra2,
    input  lu_ready, busy_rs1, busy_rs2, busy_rd, we, wa, wd, byp1_hit, byp2_hit, byp_data
  );
  modport slave (
    input  alu_valid, alu_rd, alu_wd, lu_valid, lu_rd, lu_wd, issue_valid, issue_rd, ra1, ra2,
    output lu_ready, busy_rs1, busy_rs2, busy_rd, we, wa, wd, byp1_hit, byp2_hit, byp_data
  );
`else
  modport master (
    output alu_valid, alu_rd, alu_wd, lu_valid, lu_rd, lu_wd, issue_valid, issue_rd, ra1, ra2,
    input  lu_ready, busy_rs1, busy_rs2, busy_rd, we, wa, wd
  );
  modport slave (
    input  alu_valid, alu_rd, alu_wd, lu_valid, lu_rd, lu_wd, issue_valid, issue_rd, ra1, ra2,
    output lu_ready, busy_rs1, busy_rs2, busy_rd, we, wa, wd
  );
`endif
endinterface

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of write-back entries with power-of-two depth.
module wb_fifo
  import rv_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  wb_entry_t                i_data,
  output wb_entry_t                o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  wb_entry_t     r_mem [DEPTH];
  logic [AW-1:0] r_wp;
  logic [AW-1:0] r_rp;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;
  assign o_full  = r_count == CW'(DEPTH);
  assign o_empty = r_count == '0;
  assign o_count = r_count;
  assign o_data  = r_mem[r_rp];
  assign w_push  = i_push & !o_full;
  assign w_pop   = i_pop & !o_empty;
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      r_wp    <= w_push ? r_wp + 1'b1 : r_wp;
      r_rp    <= w_pop ? r_rp + 1'b1 : r_rp;
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= i_data;
  end
endmodule

// File: rtl/rf_wb_ctrl.sv
// rf_wb_ctrl: merges ALU and long-latency results onto the register-file write port
// and tracks outstanding long-latency destinations. Optional forwarding: RF_WB_BYPASS_EN.
module rf_wb_ctrl
  import rv_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input logic         clk,
  input logic         rstn,
  rf_wb_ctrl_if.slave bus
);
  wb_entry_t                   w_head;
  wb_entry_t                   w_lu;
  logic                        w_full;
  logic                        w_empty;
  logic                        w_push;
  logic                        w_pop;
  logic [$clog2(FIFO_DEPTH):0] w_count;
  logic                        w_unused;
  logic                        r_we;
  logic [REG_AW-1:0]           r_wa;
  logic [XLEN-1:0]             r_wd;
  logic [NUM_REGS-1:0]         r_busy;
  logic [NUM_REGS-1:0]         w_busy_nxt;
  assign bus.lu_ready = !w_full;
  assign w_push       = bus.lu_valid & !w_full;
  assign w_pop        = !bus.alu_valid & !w_empty;
  assign w_lu         = '{rd: bus.lu_rd, wd: bus.lu_wd};
  assign w_unused     = ^w_count;
  wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_lu),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );
  // Clear before set so a same-cycle issue of the popped rd keeps it busy.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_pop && w_head.rd != '0) w_busy_nxt[w_head.rd] = 1'b0;
    if (bus.issue_valid && bus.issue_rd != '0) w_busy_nxt[bus.issue_rd] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_we   <= 1'b0;
      r_wa   <= '0;
      r_wd   <= '0;
      r_busy <= '0;
    end else begin
      r_we   <= bus.alu_valid ? bus.alu_rd != '0 : w_pop && w_head.rd != '0;
      r_wa   <= bus.alu_valid ? bus.alu_rd : w_pop ? w_head.rd : r_wa;
      r_wd   <= bus.alu_valid ? bus.alu_wd : w_pop ? w_head.wd : r_wd;
      r_busy <= w_busy_nxt;
    end
  end
  assign bus.we       = r_we;
  assign bus.wa       = r_wa;
  assign bus.wd       = r_wd;
  assign bus.busy_rs1 = r_busy[bus.ra1];
  assign bus.busy_rs2 = r_busy[bus.ra2];
  assign bus.busy_rd  = r_busy[bus.issue_rd];
`ifdef RF_WB_BYPASS_EN
  assign bus.byp1_hit = r_we & (r_wa == bus.ra1) & (bus.ra1 != '0);
  assign bus.byp2_hit = r_we & (r_wa == bus.ra2) & (bus.ra2 != '0);
  assign bus.byp_data = r_wd;
`endif
`ifdef SIM
  always @(posedge clk) begin
    if (rstn) begin
      assert (!(bus.issue_valid && bus.busy_rd));
      assert (!(bus.alu_valid && bus.alu_rd != '0 && r_busy[bus.alu_rd]));
    end
  end
`endif
endmodule

// File: tb/tb_rf_wb_ctrl.sv
// tb_rf_wb_ctrl: random and directed traffic against a queue-based reference model with a write scoreboard.
module tb_rf_wb_ctrl;
  import rv_pkg::*;
  localparam int DEPTH = 4;
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] wd;
  } ent_t;
  typedef struct {
    int          t;
    logic [4:0]  rd;
    logic [31:0] wd;
  } exp_t;
  logic        clk;
  logic        rstn;
  int          n_tests;
  int          n_fail;
  int          cyc;
  logic        last_acc;
  logic [31:0] mb;
  ent_t        mq[$];
  exp_t        exp_q[$];
  logic [4:0]  pend[$];
  rf_wb_ctrl_if bus();
  rf_wb_ctrl #(.FIFO_DEPTH(DEPTH)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at cycle %0d", nm, got, want, cyc);
    end
  endtask
  task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] awd,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] lwd,
                       input logic iv, input logic [4:0] ird, input logic [4:0] r1, input logic [4:0] r2);
    bus.alu_valid = av; bus.alu_rd = ard; bus.alu_wd = awd;
    bus.lu_valid = lv; bus.lu_rd = lrd; bus.lu_wd = lwd;
    bus.issue_valid = iv; bus.issue_rd = ird; bus.ra1 = r1; bus.ra2 = r2;
  endtask
  task automatic step(input logic av, input logic [4:0] ard, input logic [31:0] awd,
                      input logic lv, input logic [4:0] lrd, input logic [31:0] lwd,
                      input logic iv, input logic [4:0] ird, input logic [4:0] r1, input logic [4:0] r2);
    ent_t e;
    exp_t x;
    logic ready;
    @(negedge clk);
    drive(av, ard, awd, lv, lrd, lwd, iv, ird, r1, r2);
    #1;
    ready = mq.size() < DEPTH;
    chk("lu_ready", bus.lu_ready, ready);
    chk("busy_rs1", bus.busy_rs1, mb[r1]);
    chk("busy_rs2", bus.busy_rs2, mb[r2]);
    chk("busy_rd", bus.busy_rd, mb[ird]);
    x.t = cyc + 1;
    if (av) begin
      if (ard != 0) begin x.rd = ard; x.wd = awd; exp_q.push_back(x); end
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      if (e.rd != 0) begin x.rd = e.rd; x.wd = e.wd; exp_q.push_back(x); mb[e.rd] = 1'b0; end
    end
    if (iv && ird != 0) mb[ird] = 1'b1;
    last_acc = lv && ready;
    if (last_acc) begin e.rd = lrd; e.wd = lwd; mq.push_back(e); end
  endtask
  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (bus.we || (exp_q.size() > 0 && exp_q[0].t == cyc)) begin
        if (exp_q.size() == 0) chk("spurious_we", bus.we, 0);
        else begin
          e = exp_q.pop_front();
          chk("we", bus.we, 1);
          chk("wb_cycle", 64'(cyc), 64'(e.t));
          chk("wa", bus.wa, e.rd);
          chk("wd", bus.wd, e.wd);
        end
      end
    end
  end
  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
  initial begin
    logic av, lv, iv;
    logic [4:0] ard, ird, lrd;
    n_tests = 0; n_fail = 0; cyc = 0; mb = '0; last_acc = 0;
    rstn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_we", bus.we, 0);
    chk("rst_wa", bus.wa, 0);
    chk("rst_wd", bus.wd, 0);
    chk("rst_lu_ready", bus.lu_ready, 1);
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    // ALU-only, including rd=0 and hold of wa/wd while idle
    step(1, 5, 32'h1234, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 32'hBEEF, 0, 0, 0, 0, 0, 0, 0);
    idle(1);
    idle(1);
    chk("hold_wa", bus.wa, 0);
    chk("hold_wd", bus.wd, 32'hBEEF);
    // issue rd 7, LU write-back with ALU idle
    step(0, 0, 0, 0, 0, 0, 1, 7, 0, 0);
    step(0, 0, 0, 1, 7, 32'hDEAD, 0, 0, 7, 0);
    idle(1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 7, 7);
    // collision: three cycles of ALU and LU together, then drain
    step(1, 1, 32'h11, 1, 10, 32'hA0, 0, 0, 0, 0);
    step(1, 2, 32'h22, 1, 11, 32'hA1, 0, 0, 0, 0);
    step(1, 4, 32'h44, 1, 0, 32'hA2, 0, 0, 0, 0);
    idle(4);
    // fill under constant ALU traffic, then one bubble
    for (int i = 0; i < 5; i++) step(1, 5'(i + 1), $urandom, 1, 5'(12 + i), $urandom, 0, 0, 0, 0);
    step(1, 6, 32'h66, 1, 20, 32'h20, 0, 0, 0, 0);
    step(0, 0, 0, 1, 21, 32'h21, 0, 0, 0, 0);
    step(1, 7, 32'h77, 1, 22, 32'h22, 0, 0, 0, 0);
    idle(6);
    // set and clear of the same register in one cycle
    step(0, 0, 0, 0, 0, 0, 1, 9, 0, 0);
    step(0, 0, 0, 1, 9, 32'h99, 0, 0, 9, 0);
    step(0, 0, 0, 0, 0, 0, 1, 9, 9, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 9, 9);
    // reset with two entries queued and busy[3]
    step(0, 0, 0, 0, 0, 0, 1, 3, 0, 0);
    step(1, 1, 32'h1, 1, 3, 32'h33, 0, 0, 3, 0);
    step(1, 2, 32'h2, 1, 3, 32'h34, 0, 0, 3, 0);
    @(negedge clk);
    rstn = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 3, 3, 3);
    #1;
    chk("mid_rst_we", bus.we, 0);
    chk("mid_rst_lu_ready", bus.lu_ready, 1);
    chk("mid_rst_busy_rs1", bus.busy_rs1, 0);
    chk("mid_rst_busy_rs2", bus.busy_rs2, 0);
    chk("mid_rst_busy_rd", bus.busy_rd, 0);
    mq.delete(); exp_q.delete(); mb = '0;
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 3, 9);
    idle(4);
    // random traffic honouring the decode rules
    for (int k = 0; k < 2000; k++) begin
      ard = 5'($urandom_range(31));
      av  = ($urandom_range(1) == 1) && !mb[ard];
      ird = 5'($urandom_range(31));
      iv  = ($urandom_range(3) == 0) && !mb[ird] && pend.size() < 8;
      lv  = pend.size() > 0 && $urandom_range(3) != 0;
      lrd = lv ? pend[0] : 5'd0;
      step(av, ard, $urandom, lv, lrd, $urandom, iv, ird, 5'($urandom_range(31)), 5'($urandom_range(31)));
      if (lv && last_acc) void'(pend.pop_front());
      if (iv) pend.push_back(ird);
    end
    idle(10);
    chk("scoreboard_drained", 64'(exp_q.size()), 0);
    chk("model_fifo_drained", 64'(mq.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
